im_loader: RTL

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader_if.sv | 38 +++
 rtl/im_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/im_loader_if.sv
// -----------------------------------------------------------------------------
// im_loader_if
// Groups the handshake and memory-write signals of the instruction-memory
// loader. The loader itself uses the slave modport. The controller or bench
// that drives it uses the master modport.
//   start/len              : load request and word count (master -> loader)
//   byte_in/byte_valid     : serial program bytes (master -> loader)
//   byte_ready             : loader accepts a byte this cycle (loader -> master)
//   im_we/im_addr/im_wdata : instruction-memory write port (loader -> master)
//   cpu_hold/busy          : a load is in progress (loader -> master)
//   done/err               : completion and rejected-start pulses (loader -> master)
// -----------------------------------------------------------------------------
interface im_loader_if #(
   parameter int LEN_W = 7
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic             im_we;
   logic [31:0]      im_addr;
   logic [31:0]      im_wdata;
   logic             cpu_hold;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, len, byte_in, byte_valid,
      input  byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err
   );

   modport slave (
      input  start, len, byte_in, byte_valid,
      output byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err
   );
endinterface

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
// Loads a program into instruction memory from a serial byte stream. A start
// request with a word count of 1..DEPTH begins a load. Each group of four
// bytes is assembled big-endian into one word. That word is written to
// consecutive word addresses starting at 0. The CPU is held for the whole load.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : im_loader_if slave (request, byte stream, memory write, status)
// -----------------------------------------------------------------------------
module im_loader #(
   parameter int DEPTH = 64,
   parameter int LEN_W = 7
) (
   input  logic        clk,
   input  logic        rst,
   im_loader_if.slave  bus
);

   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] word_q, word_d;
   logic [1:0]       bcnt_q, bcnt_d;
   // The word is written on the cycle after its 4th byte arrives, so only the
   // first three bytes need to be kept here.
   logic [23:0]      shreg_q, shreg_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             err_q, err_d;

   logic             len_ok;
   logic [LEN_W-1:0] word_inc;

   assign len_ok   = (bus.len != '0) && (bus.len <= DEPTH_L);
   assign word_inc = word_q + LEN_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         word_q  <= '0;
         bcnt_q  <= '0;
         shreg_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         word_q  <= word_d;
         bcnt_q  <= bcnt_d;
         shreg_q <= shreg_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      word_d  = word_q;
      bcnt_d  = bcnt_q;
      shreg_d = shreg_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (len_ok) begin
                  len_d   = bus.len;
                  word_d  = '0;
                  bcnt_d  = '0;
                  state_d = RECV;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         RECV: begin
            err_d = bus.start;
            if (bus.byte_valid) begin
               shreg_d = {shreg_q[15:0], bus.byte_in};
               bcnt_d  = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  // The write port registers are loaded here, so im_addr and
                  // im_wdata hold their values once the write cycle ends.
                  addr_d  = {{(32-LEN_W){1'b0}}, word_q};
                  wdata_d = {shreg_q, bus.byte_in};
                  state_d = WRITE;
               end
            end
         end

         WRITE: begin
            err_d   = bus.start;
            word_d  = word_inc;
            bcnt_d  = '0;
            state_d = (word_inc == len_q) ? DONE : RECV;
         end

         DONE: begin
            err_d   = bus.start;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced low while rst is high. This keeps them quiet even
   // before the reset edge has been sampled.
   assign bus.byte_ready = (state_q == RECV)  & ~rst;
   assign bus.im_we      = (state_q == WRITE) & ~rst;
   assign bus.busy       = (state_q != IDLE)  & ~rst;
   assign bus.cpu_hold   = (state_q != IDLE)  & ~rst;
   assign bus.done       = (state_q == DONE)  & ~rst;
   assign bus.err        = err_q & ~rst;
   assign bus.im_addr    = rst ? 32'd0 : addr_q;
   assign bus.im_wdata   = rst ? 32'd0 : wdata_q;

endmodule
